// File: rtl/breakout_pkg.sv
// Shared types and constants for the Breakout brick layer.
package breakout_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef logic [1:0] hp_t;

    localparam rgb_t COL_HP3 = '{r: 8'h80, g: 8'h1F, b: 8'h80};
    localparam rgb_t COL_HP2 = '{r: 8'h80, g: 8'hFF, b: 8'h55};
    localparam rgb_t COL_HP1 = '{r: 8'h10, g: 8'hA2, b: 8'h01};

    // Starting hit points of a brick in the given row: HP_MAX - row, floored at 1.
    function automatic int unsigned load_hp(input int unsigned hp_max, input int unsigned row);
        return (hp_max > row + 32'd1) ? hp_max - row : 32'd1;
    endfunction

endpackage

// File: rtl/brick_field_renderer_if.sv
// Hit request/acknowledge channel between collision logic and the brick field.
interface brick_field_renderer_if #(
    parameter int unsigned COL_W = 3,
    parameter int unsigned ROW_W = 2
) ();
    logic             hit_req;
    logic [COL_W-1:0] hit_col;
    logic [ROW_W-1:0] hit_row;
    logic             hit_ack;
    logic             hit_destroyed;
    logic             hit_miss;

    modport master (
        output hit_req, hit_col, hit_row,
        input  hit_ack, hit_destroyed, hit_miss
    );

    modport slave (
        input  hit_req, hit_col, hit_row,
        output hit_ack, hit_destroyed, hit_miss
    );
endinterface

// File: rtl/brick_locator.sv
// Render stage 1: maps (DrawX, DrawY) to a brick cell and registers {in_brick, col, row}.
module brick_locator
    import breakout_pkg::*;
#(
    parameter int unsigned COLS    = 8,
    parameter int unsigned ROWS    = 4,
    parameter int unsigned BLOCK_W = 80,
    parameter int unsigned BLOCK_H = 20,
    parameter int unsigned LEFT_X  = 0,
    parameter int unsigned TOP_Y   = 0,
    parameter int unsigned GAP     = 2,
    parameter int unsigned COL_W   = 3,
    parameter int unsigned ROW_W   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       draw_x_i,
    input  logic [9:0]       draw_y_i,
    output logic             in_brick_o,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o
);

    localparam logic [9:0] LX = 10'(LEFT_X);
    localparam logic [9:0] TY = 10'(TOP_Y);
    localparam logic [9:0] BW = 10'(BLOCK_W);
    localparam logic [9:0] BH = 10'(BLOCK_H);

    logic [9:0]       dx, dy, qx, qy, rx, ry;
    logic             in_x, in_y;
    logic             in_brick_d, in_brick_q;
    logic [COL_W-1:0] col_d, col_q;
    logic [ROW_W-1:0] row_d, row_q;

    // Constant divide; the full quotient is range-checked before truncation.
    always_comb begin
        dx         = draw_x_i - LX;
        dy         = draw_y_i - TY;
        qx         = dx / BW;
        rx         = dx % BW;
        qy         = dy / BH;
        ry         = dy % BH;
        in_x       = (draw_x_i >= LX) && (qx < 10'(COLS)) && (rx < 10'(BLOCK_W - GAP));
        in_y       = (draw_y_i >= TY) && (qy < 10'(ROWS)) && (ry < 10'(BLOCK_H - GAP));
        in_brick_d = in_x && in_y;
        col_d      = in_brick_d ? COL_W'(qx) : '0;
        row_d      = in_brick_d ? ROW_W'(qy) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_brick_q <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
        end else begin
            in_brick_q <= in_brick_d;
            col_q      <= col_d;
            row_q      <= row_d;
        end
    end

    assign in_brick_o = in_brick_q;
    assign col_o      = col_q;
    assign row_o      = row_q;

endmodule

// File: rtl/brick_field_renderer.sv
// Brick field: per-brick hit points, hit req/ack servicing and the 2-stage brick render pipeline.
module brick_field_renderer
    import breakout_pkg::*;
#(
    parameter int unsigned COLS    = 8,
    parameter int unsigned ROWS    = 4,
    parameter int unsigned BLOCK_W = 80,
    parameter int unsigned BLOCK_H = 20,
    parameter int unsigned LEFT_X  = 0,
    parameter int unsigned TOP_Y   = 0,
    parameter int unsigned GAP     = 2,
    parameter int unsigned HP_MAX  = 3
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic [9:0]                       DrawX,
    input  logic [9:0]                       DrawY,
    input  logic                             load,
    brick_field_renderer_if.slave            hit,
    output logic                             brick_on,
    output logic [7:0]                       Red,
    output logic [7:0]                       Green,
    output logic [7:0]                       Blue,
    output logic [$clog2(COLS*ROWS+1)-1:0]   bricks_left,
    output logic                             field_clear
);

    localparam int unsigned NB     = COLS * ROWS;
    localparam int unsigned IDX_W  = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned HP_W   = $clog2(HP_MAX + 1);
    localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned LEFT_W = $clog2(NB + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACK  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              ack_q, ack_d, dest_q, dest_d, miss_q, miss_d, clear_q, clear_d;
    logic [LEFT_W-1:0] left_q, left_d;
    logic [HP_W-1:0]   hp_q [NB];
    logic [HP_W-1:0]   hp_d [NB];

    logic              hit_in_range;
    logic [IDX_W-1:0]  hit_idx;
    logic [HP_W-1:0]   hit_hp;

    logic              loc_in;
    logic [COL_W-1:0]  loc_col;
    logic [ROW_W-1:0]  loc_row;
    logic [IDX_W-1:0]  pix_idx;
    logic [HP_W-1:0]   pix_hp;
    logic              on_q, on_d;
    rgb_t              rgb_q, rgb_d;

    brick_locator #(
        .COLS(COLS), .ROWS(ROWS), .BLOCK_W(BLOCK_W), .BLOCK_H(BLOCK_H),
        .LEFT_X(LEFT_X), .TOP_Y(TOP_Y), .GAP(GAP), .COL_W(COL_W), .ROW_W(ROW_W)
    ) u_locator (
        .clk       (Clk),
        .rst       (Reset),
        .draw_x_i  (DrawX),
        .draw_y_i  (DrawY),
        .in_brick_o(loc_in),
        .col_o     (loc_col),
        .row_o     (loc_row)
    );

    // Hit FSM and level state; load has priority and drops any pending request.
    always_comb begin
        state_d      = IDLE;
        ack_d        = 1'b0;
        dest_d       = 1'b0;
        miss_d       = 1'b0;
        clear_d      = 1'b0;
        hp_d         = hp_q;
        left_d       = left_q;
        hit_in_range = (32'(hit.hit_col) < COLS) && (32'(hit.hit_row) < ROWS);
        hit_idx      = IDX_W'(32'(hit.hit_row) * COLS + 32'(hit.hit_col));
        hit_hp       = hit_in_range ? hp_q[hit_idx] : '0;

        if (load) begin
            for (int unsigned i = 0; i < NB; i++) begin
                hp_d[i] = HP_W'(load_hp(HP_MAX, i / COLS));
            end
            left_d = LEFT_W'(NB);
        end else if (state_q == IDLE && hit.hit_req) begin
            state_d = ACK;
            ack_d   = 1'b1;
            if (hit_hp != '0) begin
                hp_d[hit_idx] = hit_hp - HP_W'(1);
                if (hit_hp == HP_W'(1)) begin
                    dest_d  = 1'b1;
                    left_d  = left_q - LEFT_W'(1);
                    clear_d = (left_q == LEFT_W'(1));
                end
            end else begin
                miss_d = 1'b1;
            end
        end
    end

    // Render stage 2: live HP lookup and colour selection.
    always_comb begin
        pix_idx = IDX_W'(32'(loc_row) * COLS + 32'(loc_col));
        pix_hp  = hp_q[pix_idx];
        on_d    = loc_in && (pix_hp != '0);
        rgb_d   = '0;
        if (on_d) begin
            if (32'(pix_hp) >= 32'd3)      rgb_d = COL_HP3;
            else if (32'(pix_hp) == 32'd2) rgb_d = COL_HP2;
            else                           rgb_d = COL_HP1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            dest_q  <= 1'b0;
            miss_q  <= 1'b0;
            clear_q <= 1'b0;
            left_q  <= '0;
            hp_q    <= '{default: '0};
            on_q    <= 1'b0;
            rgb_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            dest_q  <= dest_d;
            miss_q  <= miss_d;
            clear_q <= clear_d;
            left_q  <= left_d;
            hp_q    <= hp_d;
            on_q    <= on_d;
            rgb_q   <= rgb_d;
        end
    end

    assign hit.hit_ack       = ack_q;
    assign hit.hit_destroyed = dest_q;
    assign hit.hit_miss      = miss_q;
    assign brick_on          = on_q;
    assign Red               = rgb_q.r;
    assign Green             = rgb_q.g;
    assign Blue              = rgb_q.b;
    assign bricks_left       = left_q;
    assign field_clear       = clear_q;

endmodule

// File: tb/tb_brick_field_renderer.sv
// Directed bench for brick_field_renderer: default 8x4 field plus a 6-column instance for out-of-range hits.
module tb_brick_field_renderer;

    logic       Clk, Reset, load, load6;
    logic [9:0] DrawX, DrawY;
    logic       brick_on, on6, field_clear, clr6;
    logic [7:0] Red, Green, Blue, r6, g6, b6;
    logic [5:0] bricks_left;
    logic [4:0] left6;
    int         ntot, nbad;
    int         clr_count = 0;

    brick_field_renderer_if #(.COL_W(3), .ROW_W(2)) hif ();
    brick_field_renderer_if #(.COL_W(3), .ROW_W(2)) hif6 ();

    brick_field_renderer dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .load(load),
        .hit(hif.slave), .brick_on(brick_on), .Red(Red), .Green(Green), .Blue(Blue),
        .bricks_left(bricks_left), .field_clear(field_clear)
    );

    brick_field_renderer #(.COLS(6)) dut6 (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .load(load6),
        .hit(hif6.slave), .brick_on(on6), .Red(r6), .Green(g6), .Blue(b6),
        .bricks_left(left6), .field_clear(clr6)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) if (field_clear === 1'b1) clr_count++;

    task step;
        @(posedge Clk);
        #1;
    endtask

    task show(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        step;
        step;
    endtask

    // Returns {ack, destroyed, miss, field_clear} seen at the ack; all zero if no ack within 4 cycles.
    task send_hit(input int c, input int r, output logic [3:0] res);
        res = 4'b0;
        hif.hit_col = 3'(c);
        hif.hit_row = 2'(r);
        hif.hit_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step;
            if (hif.hit_ack === 1'b1) begin
                res = {1'b1, hif.hit_destroyed, hif.hit_miss, field_clear};
                break;
            end
        end
        hif.hit_req = 1'b0;
        step;
    endtask

    task test_reset;
        int on_cnt;
        Reset = 1'b1;
        step; step; step;
        Reset = 1'b0;
        step;
        ntot++; if (bricks_left !== 6'd0) begin nbad++; $display("FAIL reset_left: got %0d want 0", bricks_left); end
        ntot++; if ({hif.hit_ack, hif.hit_destroyed, hif.hit_miss, field_clear} !== 4'b0) begin
            nbad++; $display("FAIL reset_hit_outs: got %b want 0000", {hif.hit_ack, hif.hit_destroyed, hif.hit_miss, field_clear}); end
        ntot++; if ({brick_on, Red, Green, Blue} !== 25'd0) begin
            nbad++; $display("FAIL reset_pixel: got %h want 0", {brick_on, Red, Green, Blue}); end
        on_cnt = 0;
        DrawY = 10'd5;
        for (int x = 0; x < 640; x++) begin
            DrawX = 10'(x);
            step;
            if (brick_on !== 1'b0 || {Red, Green, Blue} !== 24'd0) on_cnt++;
        end
        step; step;
        if (brick_on !== 1'b0) on_cnt++;
        ntot++; if (on_cnt !== 0) begin nbad++; $display("FAIL reset_sweep: got %0d lit pixels want 0", on_cnt); end
    endtask

    task test_load_pixels;
        load = 1'b1;
        step;
        load = 1'b0;
        ntot++; if (bricks_left !== 6'd32) begin nbad++; $display("FAIL load_left: got %0d want 32", bricks_left); end
        show(40, 5);
        ntot++; if ({brick_on, Red, Green, Blue} !== {1'b1, 24'h801F80}) begin
            nbad++; $display("FAIL pix_40_5: got %h want 1801f80", {brick_on, Red, Green, Blue}); end
        show(79, 5);
        ntot++; if ({brick_on, Red, Green, Blue} !== 25'd0) begin
            nbad++; $display("FAIL pix_gap_x: got %h want 0", {brick_on, Red, Green, Blue}); end
        show(40, 65);
        ntot++; if ({brick_on, Red, Green, Blue} !== {1'b1, 24'h10A201}) begin
            nbad++; $display("FAIL pix_row3: got %h want 110a201", {brick_on, Red, Green, Blue}); end
        show(40, 25);
        ntot++; if ({brick_on, Red, Green, Blue} !== {1'b1, 24'h80FF55}) begin
            nbad++; $display("FAIL pix_row1: got %h want 180ff55", {brick_on, Red, Green, Blue}); end
        show(40, 78);
        ntot++; if ({brick_on, Red, Green, Blue} !== 25'd0) begin
            nbad++; $display("FAIL pix_gap_y: got %h want 0", {brick_on, Red, Green, Blue}); end
        show(640, 5);
        ntot++; if ({brick_on, Red, Green, Blue} !== 25'd0) begin
            nbad++; $display("FAIL pix_col8: got %h want 0", {brick_on, Red, Green, Blue}); end
        show(635, 85);
        ntot++; if ({brick_on, Red, Green, Blue} !== 25'd0) begin
            nbad++; $display("FAIL pix_row4: got %h want 0", {brick_on, Red, Green, Blue}); end
    endtask

    task test_hits;
        logic [3:0] res;
        send_hit(0, 0, res);
        ntot++; if (res !== 4'b1000) begin nbad++; $display("FAIL hit1: got %b want 1000", res); end
        show(40, 5);
        ntot++; if ({brick_on, Red, Green, Blue} !== {1'b1, 24'h80FF55}) begin
            nbad++; $display("FAIL hit1_pix: got %h want 180ff55", {brick_on, Red, Green, Blue}); end
        send_hit(0, 0, res);
        ntot++; if (res !== 4'b1000) begin nbad++; $display("FAIL hit2: got %b want 1000", res); end
        show(40, 5);
        ntot++; if ({brick_on, Red, Green, Blue} !== {1'b1, 24'h10A201}) begin
            nbad++; $display("FAIL hit2_pix: got %h want 110a201", {brick_on, Red, Green, Blue}); end
        send_hit(0, 0, res);
        ntot++; if (res !== 4'b1100) begin nbad++; $display("FAIL hit3: got %b want 1100", res); end
        ntot++; if (bricks_left !== 6'd31) begin nbad++; $display("FAIL hit3_left: got %0d want 31", bricks_left); end
        show(40, 5);
        ntot++; if ({brick_on, Red, Green, Blue} !== 25'd0) begin
            nbad++; $display("FAIL hit3_pix: got %h want 0", {brick_on, Red, Green, Blue}); end
        send_hit(0, 0, res);
        ntot++; if (res !== 4'b1010) begin nbad++; $display("FAIL hit4_miss: got %b want 1010", res); end
        ntot++; if (bricks_left !== 6'd31) begin nbad++; $display("FAIL hit4_left: got %0d want 31", bricks_left); end
        show(120, 5);
        ntot++; if ({brick_on, Red, Green, Blue} !== {1'b1, 24'h801F80}) begin
            nbad++; $display("FAIL neighbour_pix: got %h want 1801f80", {brick_on, Red, Green, Blue}); end
    endtask

    task test_out_of_range;
        logic [9:0] acks, misses, clrs;
        load6 = 1'b1;
        step;
        load6 = 1'b0;
        ntot++; if (left6 !== 5'd24) begin nbad++; $display("FAIL oor_load_left: got %0d want 24", left6); end
        acks = '0; misses = '0; clrs = '0;
        hif6.hit_col = 3'd7;
        hif6.hit_row = 2'd0;
        hif6.hit_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step;
            acks[i]   = hif6.hit_ack;
            misses[i] = hif6.hit_miss;
            clrs[i]   = clr6 | hif6.hit_destroyed;
        end
        hif6.hit_req = 1'b0;
        step;
        ntot++; if (acks !== 10'b0101010101) begin nbad++; $display("FAIL oor_ack_cadence: got %b want 0101010101", acks); end
        ntot++; if (misses !== 10'b0101010101) begin nbad++; $display("FAIL oor_miss: got %b want 0101010101", misses); end
        ntot++; if (clrs !== 10'b0) begin nbad++; $display("FAIL oor_destroy: got %b want 0", clrs); end
        ntot++; if (left6 !== 5'd24) begin nbad++; $display("FAIL oor_left: got %0d want 24", left6); end
        show(40, 5);
        ntot++; if ({on6, r6, g6, b6} !== {1'b1, 24'h801F80}) begin
            nbad++; $display("FAIL oor_pix: got %h want 1801f80", {on6, r6, g6, b6}); end
        show(500, 5);
        ntot++; if ({on6, r6, g6, b6} !== 25'd0) begin
            nbad++; $display("FAIL oor_pix_col6: got %h want 0", {on6, r6, g6, b6}); end
    endtask

    task test_clear_field;
        logic [3:0] res, exp;
        int hp, base;
        base = clr_count;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (r == 0 && c == 0) continue;
                hp = (r == 0) ? 3 : (r == 1) ? 2 : 1;
                for (int k = 1; k <= hp; k++) begin
                    send_hit(c, r, res);
                    exp = {1'b1, (k == hp), 1'b0, (k == hp && r == 3 && c == 7)};
                    ntot++; if (res !== exp) begin
                        nbad++; $display("FAIL clear_hit r%0d c%0d k%0d: got %b want %b", r, c, k, res, exp); end
                end
            end
        end
        ntot++; if (bricks_left !== 6'd0) begin nbad++; $display("FAIL clear_left: got %0d want 0", bricks_left); end
        ntot++; if (clr_count - base !== 1) begin nbad++; $display("FAIL clear_pulses: got %0d want 1", clr_count - base); end
        show(40, 65);
        ntot++; if ({brick_on, Red, Green, Blue} !== 25'd0) begin
            nbad++; $display("FAIL clear_pix: got %h want 0", {brick_on, Red, Green, Blue}); end
    endtask

    task test_simultaneous;
        load = 1'b1;
        hif.hit_col = 3'd0;
        hif.hit_row = 2'd0;
        hif.hit_req = 1'b1;
        step;
        load = 1'b0;
        ntot++; if (hif.hit_ack !== 1'b0) begin nbad++; $display("FAIL sim_no_ack: got %b want 0", hif.hit_ack); end
        ntot++; if (bricks_left !== 6'd32) begin nbad++; $display("FAIL sim_left_load: got %0d want 32", bricks_left); end
        step;
        ntot++; if ({hif.hit_ack, hif.hit_destroyed, hif.hit_miss} !== 3'b100) begin
            nbad++; $display("FAIL sim_ack: got %b want 100", {hif.hit_ack, hif.hit_destroyed, hif.hit_miss}); end
        ntot++; if (bricks_left !== 6'd32) begin nbad++; $display("FAIL sim_left: got %0d want 32", bricks_left); end
        hif.hit_req = 1'b0;
        step;
        show(40, 5);
        ntot++; if ({brick_on, Red, Green, Blue} !== {1'b1, 24'h80FF55}) begin
            nbad++; $display("FAIL sim_pix_hp2: got %h want 180ff55", {brick_on, Red, Green, Blue}); end
    endtask

    task test_reset_mid_ack;
        hif.hit_col = 3'd1;
        hif.hit_row = 2'd0;
        hif.hit_req = 1'b1;
        step;
        ntot++; if (hif.hit_ack !== 1'b1) begin nbad++; $display("FAIL rma_ack: got %b want 1", hif.hit_ack); end
        Reset = 1'b1;
        hif.hit_req = 1'b0;
        step;
        ntot++; if ({hif.hit_ack, hif.hit_destroyed, hif.hit_miss, field_clear} !== 4'b0) begin
            nbad++; $display("FAIL rma_hit_outs: got %b want 0000", {hif.hit_ack, hif.hit_destroyed, hif.hit_miss, field_clear}); end
        ntot++; if (bricks_left !== 6'd0) begin nbad++; $display("FAIL rma_left: got %0d want 0", bricks_left); end
        ntot++; if ({brick_on, Red, Green, Blue} !== 25'd0) begin
            nbad++; $display("FAIL rma_pix: got %h want 0", {brick_on, Red, Green, Blue}); end
        Reset = 1'b0;
        step; step;
        ntot++; if ({hif.hit_ack, brick_on} !== 2'b00) begin
            nbad++; $display("FAIL rma_after: got %b want 00", {hif.hit_ack, brick_on}); end
    endtask

    initial begin
        ntot = 0;
        nbad = 0;
        Reset = 1'b1;
        load = 1'b0;
        load6 = 1'b0;
        DrawX = '0;
        DrawY = '0;
        hif.hit_req = 1'b0;
        hif.hit_col = '0;
        hif.hit_row = '0;
        hif6.hit_req = 1'b0;
        hif6.hit_col = '0;
        hif6.hit_row = '0;
        test_reset;
        test_load_pixels;
        test_hits;
        test_out_of_range;
        test_clear_field;
        test_simultaneous;
        test_reset_mid_ack;
        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

endmodule

// File: doc/brick_field_renderer.md
# brick_field_renderer

Parametrised brick-field block for the Breakout display path. It owns the per-brick hit-point state, accepts hit requests from collision logic over a req/ack handshake, and renders the brick layer for each (DrawX, DrawY) through a 2-stage registered pipeline. It sits between the VGA controller and the top-level colour mapper. The colour mapper composites the ball and paddle over this block's output using `brick_on`.

## Interface
Parameters:
- COLS, 8, bricks per row
- ROWS, 4, brick rows
- BLOCK_W, 80, brick pitch in X (pixels)
- BLOCK_H, 20, brick pitch in Y (pixels)
- LEFT_X, 0, X of the field's left edge
- TOP_Y, 0, Y of the field's top edge
- GAP, 2, background pixels at the right and bottom edge of each brick cell
- HP_MAX, 3, maximum hit points per brick (≥1)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- DrawX  in  10  current pixel X
- DrawY  in  10  current pixel Y
- load  in  1  one-cycle pulse that loads a fresh level
- hit_req  in  1  hit request; held until `hit_ack`
- hit_col  in  $clog2(COLS)  column of the brick hit; stable while `hit_req` is high
- hit_row  in  $clog2(ROWS)  row of the brick hit; stable while `hit_req` is high
- hit_ack  out  1  one-cycle acknowledge
- hit_destroyed  out  1  valid with `hit_ack`: brick reached 0 HP
- hit_miss  out  1  valid with `hit_ack`: brick already dead or index out of range
- brick_on  out  1  current pipelined pixel lies on a live brick
- Red, Green, Blue  out  8 each  brick colour; 0 when `brick_on`=0
- bricks_left  out  $clog2(COLS*ROWS+1)  count of live bricks
- field_clear  out  1  one-cycle pulse when the last brick dies

## Operation
- **State.** COLS*ROWS hit-point registers, each $clog2(HP_MAX+1) bits wide. A brick is live when its HP is nonzero.
- **Reset.** All HP = 0. `bricks_left` = 0. All outputs 0, including the pipeline registers.
- **Load.** Brick (r,c) gets HP = max(1, HP_MAX − r). `bricks_left` = COLS*ROWS. With the defaults, rows get 3, 2, 1, 1. A load discards any pending hit; it is not acked in that cycle.
- **Hit.** `hit_req` is sampled when `load`=0 and `hit_ack`=0.
  - Live brick: HP is decremented.
    - If the new HP is 0: `hit_destroyed`=1 and `bricks_left` is decremented.
    - If `bricks_left` reaches 0 this way, `field_clear` pulses in the same cycle as `hit_ack`.
  - Dead brick, or hit_col ≥ COLS, or hit_row ≥ ROWS: `hit_miss`=1, no state change.
- **Locate.** Pixel to cell mapping:
  - col = (DrawX − LEFT_X) / BLOCK_W
  - row = (DrawY − TOP_Y) / BLOCK_H
  - Division is by a constant. Differences are computed unsigned 10-bit and guarded by the checks DrawX ≥ LEFT_X and DrawY ≥ TOP_Y.
  - The pixel is in a brick when col < COLS, row < ROWS, (DrawX − LEFT_X) mod BLOCK_W < BLOCK_W − GAP, and likewise in Y.
- **Colour by HP.**
  - HP ≥ 3 → 80/1F/80
  - HP 2 → 80/FF/55
  - HP 1 → 10/A2/01
  - HP 0 or outside a brick → `brick_on`=0 and RGB 00/00/00

## Timing
- **Render latency** is 2 cycles.
  - Stage 1 registers in_brick, col and row.
  - Stage 2 reads HP and registers `brick_on` and RGB.
  - The upstream DrawX/DrawY path must be delayed by 2 cycles to align.
- **HP reads** in stage 2 use the current register value. A hit applied at edge N affects pixels in stage 2 from cycle N+1.
- **Hit handshake.**
  - `hit_req` is seen at edge N; `hit_ack`, `hit_destroyed` and `hit_miss` are high during cycle N+1 for exactly one cycle.
  - The requester drops `hit_req`, or presents a new hit, after seeing `hit_ack`.
  - `hit_req` is ignored while `hit_ack`=1. Throughput is at most one hit per 2 cycles.
- **Load and hit together.** Load wins. A request still held is serviced on the next cycle against the new level.
- **Reset mid-hit.** The pending ack is dropped. The requester must not expect an ack.
- `bricks_left` updates at the same edge as the HP change.

## Structure
- Package `breakout_pkg` holds:
  - the colour constants COL_HP3, COL_HP2, COL_HP1
  - an `rgb_t` struct {r,g,b}
  - a `hp_t` typedef sized for HP_MAX = 3
- Sub-module `brick_locator`: takes DrawX/DrawY and outputs registered {in_brick, col, row}. This is stage 1 of the pipeline.
- The top level holds the HP array, the hit FSM (IDLE and ACK states), the counter, and stage 2.

## Test plan
- **Reset, then sweep** DrawX 0..639 at DrawY=5 → `brick_on`=0 everywhere; `bricks_left`=0.
- **Load, then pixels.** Pixel (40,5) → `brick_on`=1 and RGB 80/1F/80, two cycles later. Pixel (79,5) in the gap → `brick_on`=0. Pixel (40,65), row 3 → 10/A2/01. `bricks_left`=32.
- **Three hits on (0,0).**
  - 1st hit: ack, destroyed=0; HP 3→2.
  - 2nd hit: ack, destroyed=0; HP 2→1.
  - 3rd hit: `hit_destroyed`=1, `bricks_left`=31, pixel (40,5) goes off.
  - 4th hit: `hit_miss`=1, no count change.
- **Out-of-range hit** with COLS=6 and hit_col=7 → `hit_miss`=1, state unchanged. Holding `hit_req` high continuously → ack every 2nd cycle only.
- **Clear the field.** Destroy all 32 bricks → `field_clear` pulses once with the final ack; `bricks_left`=0.
- **Simultaneous events.** `load` together with `hit_req` on (0,0) → no ack that cycle; ack next cycle with HP 2 and `bricks_left`=32. Assert Reset during the ACK cycle → outputs 0 next cycle.
